// File: rtl/lector_tabla_arbitraje_if.sv
// Signal bundle between the arbitration-table reader, the selection memory,
// the queue FIFOs and the downstream mux. The reader is the master side.
interface lector_tabla_arbitraje_if #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int TABLE_SIZE     = 8,
   parameter int SEL_BITS       = $clog2(QUEUE_QUANTITY),
   parameter int IDX_BITS       = $clog2(TABLE_SIZE)
);
   logic                             enb;
   logic [TABLE_SIZE*SEL_BITS:0]     selecciones;
   logic [QUEUE_QUANTITY-1:0]        fifo_empty;
   logic                             ready;
   logic                             valid;
   logic [SEL_BITS-1:0]              seleccion;
   logic [IDX_BITS-1:0]              indice;
   logic [QUEUE_QUANTITY-1:0]        pop;
   logic                             table_miss;
   logic [1:0]                       dbg_state;
   logic [IDX_BITS-1:0]              dbg_ptr;

   // Handshake: a grant (seleccion/indice) is offered while valid=1 and is
   // consumed on a rising edge where valid && ready; once valid rises it stays
   // up with stable payload until consumed, and pop fires in that same cycle.
   modport master (
      input  enb, selecciones, fifo_empty, ready,
      output valid, seleccion, indice, pop, table_miss, dbg_state, dbg_ptr
   );

   modport slave (
      output enb, selecciones, fifo_empty, ready,
      input  valid, seleccion, indice, pop, table_miss, dbg_state, dbg_ptr
   );
endinterface

// File: rtl/lector_tabla_arbitraje.sv
// Walks the QoS arbitration table entry by entry, skipping entries whose queue
// is empty, and issues one grant (selection code + one-hot pop) per handshake.
module lector_tabla_arbitraje #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int TABLE_SIZE     = 8,
   parameter int SEL_BITS       = $clog2(QUEUE_QUANTITY),
   parameter int IDX_BITS       = $clog2(TABLE_SIZE)
) (
   input  logic                     clk,
   input  logic                     rst,
   lector_tabla_arbitraje_if.master bus
);

   localparam int TBL_BITS = TABLE_SIZE * SEL_BITS;
   localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(TABLE_SIZE - 1);
   localparam logic [IDX_BITS:0]   LAST_SKIP = (IDX_BITS + 1)'(TABLE_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      GRANT = 2'd2
   } state_t;

   state_t                    r_state;
   logic [IDX_BITS-1:0]       r_ptr;
   logic [IDX_BITS:0]         r_skip;
   logic [TBL_BITS-1:0]       r_snap;
   logic                      r_valid;
   logic [SEL_BITS-1:0]       r_sel;
   logic [IDX_BITS-1:0]       r_idx;
   logic                      r_miss;

   logic [SEL_BITS-1:0]       w_entry;
   logic                      w_servable;
   logic                      w_wrap;
   logic [IDX_BITS-1:0]       w_ptr_next;
   logic                      w_fire;
   logic [QUEUE_QUANTITY-1:0] w_onehot;
   logic                      w_any_ready_queue;
   logic                      w_unused_msb;

   assign w_unused_msb      = bus.selecciones[TBL_BITS];
   assign w_entry           = r_snap[int'(r_ptr)*SEL_BITS +: SEL_BITS];
   assign w_wrap            = (r_ptr == LAST_IDX);
   assign w_ptr_next        = w_wrap ? '0 : r_ptr + 1'b1;
   assign w_fire            = r_valid && bus.ready;
   assign w_any_ready_queue = !(&bus.fifo_empty);

   // Entries that name a non-existent queue never match, so they count as misses.
   always_comb begin
      w_servable = 1'b0;
      w_onehot   = '0;
      for (int q = 0; q < QUEUE_QUANTITY; q++) begin
         if (w_entry == SEL_BITS'(q) && !bus.fifo_empty[q]) w_servable = 1'b1;
         if (r_sel == SEL_BITS'(q)) w_onehot[q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_skip  <= '0;
         r_snap  <= '0;
         r_valid <= 1'b0;
         r_sel   <= '0;
         r_idx   <= '0;
         r_miss  <= 1'b0;
      end else begin
         r_miss <= 1'b0;
         case (r_state)
            IDLE: begin
               r_snap <= bus.selecciones[TBL_BITS-1:0];
               if (bus.enb && w_any_ready_queue) begin
                  r_state <= SCAN;
                  r_skip  <= '0;
               end
            end
            SCAN: begin
               if (!bus.enb) begin
                  r_state <= IDLE;
               end else if (w_servable) begin
                  r_sel   <= w_entry;
                  r_idx   <= r_ptr;
                  r_valid <= 1'b1;
                  r_state <= GRANT;
               end else begin
                  r_ptr  <= w_ptr_next;
                  r_skip <= r_skip + 1'b1;
                  // A new table is only picked up at the start of a pass.
                  if (w_wrap) r_snap <= bus.selecciones[TBL_BITS-1:0];
                  if (r_skip == LAST_SKIP) begin
                     r_miss  <= 1'b1;
                     r_state <= IDLE;
                  end
               end
            end
            GRANT: begin
               if (w_fire) begin
                  r_valid <= 1'b0;
                  r_ptr   <= w_ptr_next;
                  r_skip  <= '0;
                  if (w_wrap) r_snap <= bus.selecciones[TBL_BITS-1:0];
                  r_state <= bus.enb ? SCAN : IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.valid      = r_valid;
   assign bus.seleccion  = r_sel;
   assign bus.indice     = r_idx;
   assign bus.pop        = w_fire ? w_onehot : '0;
   assign bus.table_miss = r_miss;
   assign bus.dbg_state  = r_state;
   assign bus.dbg_ptr    = r_ptr;

endmodule

// File: tb/tb_lector_tabla_arbitraje.sv
// Directed bench for the arbitration-table reader: walk, skip, miss,
// backpressure, mid-pass table change and asynchronous reset.
module tb_lector_tabla_arbitraje;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_GRANT = 2'd2;

   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   waited;
   logic saw_valid;
   logic [12:0] exp_q[$];

   lector_tabla_arbitraje_if #(.QUEUE_QUANTITY(4), .TABLE_SIZE(8)) bus ();

   lector_tabla_arbitraje #(.QUEUE_QUANTITY(4), .TABLE_SIZE(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // expected grant: cycles since previous grant (or task start), indice, seleccion
   task automatic exp_grant(input int gap, input int idx, input int sel);
      exp_q.push_back({8'(gap), 3'(idx), 2'(sel)});
   endtask

   task automatic run_grants(input int n, input int budget);
      int got;
      int cnt;
      int since;
      logic [12:0] e;
      got = 0; cnt = 0; since = 0;
      while (got < n && cnt < budget) begin
         @(negedge clk);
         cnt++; since++;
         if (bus.valid && bus.ready) begin
            e = exp_q.pop_front();
            chk("grant_gap",    since,         32'(e[12:5]));
            chk("grant_indice", bus.indice,    32'(e[4:2]));
            chk("grant_sel",    bus.seleccion, 32'(e[1:0]));
            chk("grant_pop",    bus.pop,       32'(4'b0001 << e[1:0]));
            got++;
            since = 0;
         end
      end
      chk("grant_count", got, n);
      exp_q.delete();
   endtask

   initial begin
      rst             = 1'b0;
      bus.enb         = 1'b0;
      bus.selecciones = '0;
      bus.fifo_empty  = 4'hF;
      bus.ready       = 1'b0;
      tick(); tick();

      // reset values
      chk("rst_valid", bus.valid, 0);
      chk("rst_pop", bus.pop, 0);
      chk("rst_sel", bus.seleccion, 0);
      chk("rst_idx", bus.indice, 0);
      chk("rst_miss", bus.table_miss, 0);
      chk("rst_state", bus.dbg_state, ST_IDLE);
      chk("rst_ptr", bus.dbg_ptr, 0);
      rst = 1'b1;
      tick();

      // full walk over 0,1,2,3,0,1,2,3
      bus.selecciones = 17'h0E4E4;
      bus.fifo_empty  = 4'b0000;
      bus.ready       = 1'b1;
      bus.enb         = 1'b1;
      for (int i = 0; i < 8; i++) exp_grant(2, i, i % 4);
      run_grants(8, 40);

      // queue 1 empty: each skipped entry costs one extra cycle
      bus.fifo_empty = 4'b0010;
      exp_grant(2, 0, 0); exp_grant(3, 2, 2); exp_grant(2, 3, 3);
      exp_grant(2, 4, 0); exp_grant(3, 6, 2); exp_grant(2, 7, 3);
      exp_grant(2, 0, 0);
      run_grants(7, 40);
      tick();

      // backpressure: SCAN at ptr1 (skipped), grant at ptr2 held for 3 cycles
      bus.ready = 1'b0;
      waited = 0;
      while (!bus.valid && waited < 10) begin tick(); waited++; end
      chk("bp_latency", waited, 2);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", bus.valid, 1);
         chk("bp_sel", bus.seleccion, 2);
         chk("bp_idx", bus.indice, 2);
         chk("bp_pop", bus.pop, 0);
         chk("bp_ptr", bus.dbg_ptr, 2);
         chk("bp_state", bus.dbg_state, ST_GRANT);
         tick();
      end
      bus.ready = 1'b1;
      #1;
      chk("bp_pop_fire", bus.pop, 4'b0100);
      tick();
      chk("bp_after_valid", bus.valid, 0);
      chk("bp_after_pop", bus.pop, 0);
      chk("bp_after_state", bus.dbg_state, ST_SCAN);
      chk("bp_after_ptr", bus.dbg_ptr, 3);

      // table change while indice=3 only applies after the wrap
      bus.fifo_empty = 4'b0000;
      exp_grant(1, 3, 3);
      run_grants(1, 10);
      bus.selecciones = 17'h00000;
      exp_grant(2, 4, 0); exp_grant(2, 5, 1); exp_grant(2, 6, 2); exp_grant(2, 7, 3);
      exp_grant(2, 0, 0); exp_grant(2, 1, 0); exp_grant(2, 2, 0); exp_grant(2, 3, 0);
      run_grants(8, 40);
      tick();

      // park in IDLE at ptr 4
      bus.enb = 1'b0;
      tick();
      chk("park_state", bus.dbg_state, ST_IDLE);
      chk("park_ptr", bus.dbg_ptr, 4);

      // table miss: all entries 3, queue 3 empty
      bus.selecciones = 17'h0FFFF;
      bus.fifo_empty  = 4'b1000;
      bus.enb         = 1'b1;
      waited = 0;
      saw_valid = 1'b0;
      while (!bus.table_miss && waited < 20) begin
         tick();
         waited++;
         if (bus.valid) saw_valid = 1'b1;
      end
      chk("miss_latency", waited, 9);
      chk("miss_no_valid", saw_valid, 0);
      chk("miss_state", bus.dbg_state, ST_IDLE);
      chk("miss_ptr", bus.dbg_ptr, 4);
      bus.enb = 1'b0;
      tick();
      chk("miss_pulse_width", bus.table_miss, 0);

      // reset during a pending grant
      bus.selecciones = 17'h0E4E4;
      bus.fifo_empty  = 4'b0000;
      bus.ready       = 1'b0;
      bus.enb         = 1'b1;
      waited = 0;
      while (!bus.valid && waited < 10) begin tick(); waited++; end
      chk("pre_rst_valid", bus.valid, 1);
      chk("pre_rst_idx", bus.indice, 4);
      rst       = 1'b0;
      bus.ready = 1'b1;
      #1;
      chk("arst_valid", bus.valid, 0);
      chk("arst_pop", bus.pop, 0);
      chk("arst_sel", bus.seleccion, 0);
      chk("arst_idx", bus.indice, 0);
      chk("arst_miss", bus.table_miss, 0);
      chk("arst_ptr", bus.dbg_ptr, 0);
      tick();
      rst = 1'b1;
      exp_grant(2, 0, 0); exp_grant(2, 1, 1);
      run_grants(2, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lector_tabla_arbitraje.md
# lector_tabla_arbitraje

Table-walking reader for the QoS arbitration table. It consumes the packed queue-selection table held by the selection memory and walks it entry by entry. It skips entries whose queue FIFO is empty and issues one queue grant per handshake as a one-hot pop toward the queue FIFOs and a selection code toward the output mux. It sits between the selection memory and the QUEUE_QUANTITY input FIFOs of the QoS block.

## Interface

**Parameters**
- QUEUE_QUANTITY, 4: number of queue FIFOs.
- TABLE_SIZE, 8: number of arbitration table entries.
- SEL_BITS, $clog2(QUEUE_QUANTITY): width of one table entry (derived; do not override).
- IDX_BITS, $clog2(TABLE_SIZE): width of the table pointer (derived).

**Ports**
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- enb, input, 1: run enable.
- selecciones, input, TABLE_SIZE*SEL_BITS+1: packed table. Entry i is at [i*SEL_BITS +: SEL_BITS]. The MSB is unused and ignored.
- fifo_empty, input, QUEUE_QUANTITY: per-queue empty flags.
- ready, input, 1: downstream accepts the current grant.
- valid, output, 1: grant present.
- seleccion, output, SEL_BITS: granted queue number.
- indice, output, IDX_BITS: table index that produced the grant.
- pop, output, QUEUE_QUANTITY: one-hot pop. Equals onehot(seleccion) when valid && ready, else 0 (combinational from registered state and ready).
- table_miss, output, 1: one-cycle pulse when a full table pass found no servable entry.

## Operation

- **Internal state:** state {IDLE, SCAN, GRANT}, ptr (IDX_BITS), skip counter (IDX_BITS+1), and a table snapshot register (TABLE_SIZE*SEL_BITS).
- **Snapshot loading:**
  - The snapshot loads from selecciones every cycle in IDLE.
  - It also loads on the cycle ptr wraps from TABLE_SIZE-1 to 0.
  - Changes to selecciones mid-pass take effect only from entry 0 of the next pass.
- **IDLE:** valid=0.
  - If enb && (fifo_empty != all ones): go to SCAN and clear skip.
  - Otherwise stay. ptr is retained, so the walk resumes where it stopped.
- **SCAN:** let e = snapshot entry at ptr.
  - If !enb: go to IDLE.
  - Else if fifo_empty[e]==0: register seleccion=e and indice=ptr, then go to GRANT.
  - Else: ptr = ptr+1 (wrap to 0 after TABLE_SIZE-1) and skip = skip+1.
  - If skip reaches TABLE_SIZE-1 on a miss: pulse table_miss for the next cycle, advance ptr, and go to IDLE.
- **GRANT:** valid=1. seleccion and indice are held stable.
  - On valid && ready: pop fires this cycle and ptr advances with wrap. Next state is SCAN if enb, else IDLE. skip clears.
  - Without ready: stay, with no change.
  - A grant is never retracted: enb low or fifo_empty changing during GRANT does not drop it. Only this block pops the FIFOs, so a granted queue stays non-empty.
- **Entry range:** an entry value ≥ QUEUE_QUANTITY (non-power-of-2 configurations) counts as a miss.

## Timing

- **Reset values (async on rst low):** state=IDLE, ptr=0, skip=0, snapshot=0, valid=0, seleccion=0, indice=0, pop=0, table_miss=0.
- **Start-up latency:** from enb rising in IDLE (non-empty queue present) to valid is 2 cycles (IDLE→SCAN, SCAN→GRANT), plus 1 cycle per skipped entry.
- **Throughput:** at most one grant every 2 cycles with ready held high.
- **table_miss:** asserted exactly 1 cycle, coincident with IDLE.
- **Reset during GRANT:** valid and pop drop immediately (asynchronous); ptr returns to 0.

## Test plan

1. **Reset values.** Assert rst=0 mid-run with a pending grant -> valid, pop, seleccion, indice and table_miss go 0 immediately; after release, the first grant is from indice 0.
2. **Full walk.** selecciones=17'h0E4E4 (entries 0,1,2,3,0,1,2,3), fifo_empty=4'b0000, ready=1, enb=1 -> seleccion 0,1,2,3,0,1,2,3 with indice 0..7; pop 0001,0010,0100,1000 repeating; valid every 2nd cycle.
3. **Skip empty queue.** Same table, fifo_empty=4'b0010 -> grants 0,2,3,0,2,3. Each skip adds 1 cycle: 3 cycles between the grant of 0 and the grant of 2.
4. **Table miss.** selecciones=17'h0FFFF (all entries 3), fifo_empty=4'b1000 -> no valid; after 8 SCAN cycles table_miss pulses 1 cycle; state returns to IDLE; ptr is back at its starting value.
5. **Backpressure.** ready=0 for 3 cycles while valid=1 -> seleccion and indice stable, pop=0, ptr unchanged. Raising ready -> pop one-hot for exactly 1 cycle, then SCAN.
6. **Mid-pass table change.** Change selecciones from 17'h0E4E4 to 17'h00000 while indice=3 -> entries 4..7 still yield 0,1,2,3; after the wrap every grant is queue 0.
